guess_entry_tx: RTL

Synchronous front end that turns raw pushbuttons into a 4-digit BCD guess and hands it to the game core over a valid/ack handshake. It sits between the board buttons and the guessing-game FSM, on the transmit side of the guess interface. It replaces direct button-edge clocking with one clock domain. It also provides a one-hot cursor that the display can use to highlight the digit being edited.

---
 rtl/guess_entry_tx.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/guess_entry_tx.sv
// guess_entry_tx: pushbutton front end for the guessing game.
// Synchronizes and debounces three raw buttons, edits a 4-digit BCD guess under a
// one-hot cursor, and offers the finished guess to the game core over valid/ack.
// Optional build macro AUTO_REPEAT_EN adds auto-repeat increments while iter is held.
module guess_entry_tx #(
    parameter int unsigned DB_CYCLES     = 50000,
    parameter int unsigned DB_W          = 16,
    parameter int unsigned REPEAT_CYCLES = 25000000
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        btn_iter_i,
    input  logic        btn_next_i,
    input  logic        btn_submit_i,
    input  logic        guess_ack_i,
    output logic        guess_valid_o,
    output logic [15:0] guess_o,
    output logic [3:0]  cursor_o,
    output logic        busy_o
);

    localparam int unsigned BtnIter   = 0;
    localparam int unsigned BtnNext   = 1;
    localparam int unsigned BtnSubmit = 2;
    localparam logic [DB_W-1:0] DbLast = DB_W'(DB_CYCLES - 1);

    typedef enum logic {StEdit, StHold} state_e;

    logic [2:0]      btn_raw;
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      db_q, db_d, db_prev_q;
    logic [DB_W-1:0] cnt_q [3];
    logic [DB_W-1:0] cnt_d [3];
    logic            p_iter, p_next, p_submit;
    logic            inc;
    state_e          state_q, state_d;
    logic [15:0]     guess_q, guess_d;
    logic [3:0]      cursor_q, cursor_d;

    assign btn_raw = {btn_submit_i, btn_next_i, btn_iter_i};

    // Two-flop synchronizer for all raw buttons.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: flip the level only after DB_CYCLES consecutive differing samples.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DbLast) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounced levels, their previous values and counters.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            db_q      <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q      <= db_d;
            db_prev_q <= db_q;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign p_iter   = db_q[BtnIter] & ~db_prev_q[BtnIter];
    assign p_next   = db_q[BtnNext] & ~db_prev_q[BtnNext];
    assign p_submit = db_q[BtnSubmit] & ~db_prev_q[BtnSubmit];

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RptW = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RptW-1:0] RptLast = RptW'(REPEAT_CYCLES - 1);

    logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic            rpt_fire;

    assign rpt_fire = (state_q == StEdit) && db_q[BtnIter] && (rpt_cnt_q == RptLast);

    // Repeat counter runs only while iter is held in EDIT; submit clears it.
    always_comb begin
        rpt_cnt_d = '0;
        if ((state_q == StEdit) && db_q[BtnIter] && !p_submit && !rpt_fire) begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
    end

    // Repeat counter register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    assign inc = p_iter | rpt_fire;
`else
    assign inc = p_iter;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StEdit;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: submit enters HOLD, ack returns to EDIT.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEdit: if (p_submit) state_d = StHold;
            StHold: if (guess_ack_i) state_d = StEdit;
            default: state_d = StEdit;
        endcase
    end

    // FSM outputs: the guess is offered for exactly as long as we hold.
    always_comb begin
        guess_valid_o = (state_q == StHold);
        busy_o        = (state_q == StHold);
    end

    // Guess/cursor next state; submit outranks editing, HOLD freezes everything.
    always_comb begin
        guess_d  = guess_q;
        cursor_d = cursor_q;
        if (state_q == StEdit) begin
            if (!p_submit) begin
                if (inc) begin
                    for (int i = 0; i < 4; i++) begin
                        if (cursor_q[i]) begin
                            guess_d[4*i +: 4] = (guess_q[4*i +: 4] >= 4'd9) ? 4'd0
                                                : guess_q[4*i +: 4] + 4'd1;
                        end
                    end
                end
                if (p_next) begin
                    cursor_d = {cursor_q[2:0], cursor_q[3]};
                end
            end
        end else if (guess_ack_i) begin
            guess_d  = '0;
            cursor_d = 4'b0001;
        end
    end

    // Guess and cursor registers.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            guess_q  <= '0;
            cursor_q <= 4'b0001;
        end else begin
            guess_q  <= guess_d;
            cursor_q <= cursor_d;
        end
    end

    assign guess_o  = guess_q;
    assign cursor_o = cursor_q;

endmodule
